// File: rtl/prog_sequencer.sv
// Instruction supplier for the processor DIN/Run/Done handshake: fetches from a
// 1-cycle-latency program ROM, issues one run strobe per instruction, feeds mvi immediates.
module prog_sequencer #(
  parameter int ADDR_W   = 5,
  parameter int END_ADDR = 2**ADDR_W-1,
  parameter int TIMEOUT  = 8
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              start,
  input  logic              done,
  input  logic [15:0]       mem_q,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       din,
  output logic              run,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              timeout_err,
  output logic [15:0]       instr_count
);

  localparam int TCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] END_PC    = ADDR_W'(END_ADDR);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    ISSUE = 3'd2,
    EXEC  = 3'd3,
    HALT  = 3'd4
  } state_t;

  state_t            state;
  logic              is_mvi;
  logic [15:0]       ir_shadow;
  logic [15:0]       imm_reg;
  logic [TCNT_W-1:0] tcnt;
  logic [ADDR_W-1:0] pc_plus1;
  logic [ADDR_W-1:0] pc_step;
  logic              first_exec;

  assign pc_plus1   = pc + ADDR_W'(1);
  assign pc_step    = pc + (is_mvi ? ADDR_W'(2) : ADDR_W'(1));
  assign first_exec = (state == EXEC) && (tcnt == '0);

  // During ISSUE/EXEC the ROM is already pointed at the word after the opcode,
  // so an mvi immediate is on mem_q by the first EXEC cycle.
  assign mem_addr = ((state == ISSUE) || (state == EXEC)) ? pc_plus1 : pc;

  always_comb begin
    din = is_mvi ? imm_reg : ir_shadow;
    if (state == ISSUE) begin
      din = mem_q;
    end else if (first_exec && is_mvi) begin
      din = mem_q;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state       <= IDLE;
      pc          <= '0;
      run         <= 1'b0;
      halted      <= 1'b0;
      timeout_err <= 1'b0;
      instr_count <= '0;
      is_mvi      <= 1'b0;
      ir_shadow   <= '0;
      imm_reg     <= '0;
      tcnt        <= '0;
    end else begin
      run <= 1'b0;
      case (state)
        IDLE: begin
          if (start) state <= FETCH;
        end

        FETCH: begin
          if (pc == END_PC) begin
            halted <= 1'b1;
            state  <= HALT;
          end else begin
            run   <= 1'b1;
            state <= ISSUE;
          end
        end

        ISSUE: begin
          ir_shadow <= mem_q;
          is_mvi    <= (mem_q[8:6] == 3'b001);
          tcnt      <= '0;
          // The processor cannot finish an instruction it has only just been handed.
          if (done) begin
            timeout_err <= 1'b1;
            halted      <= 1'b1;
            state       <= HALT;
          end else begin
            state <= EXEC;
          end
        end

        EXEC: begin
          if (first_exec && is_mvi) imm_reg <= mem_q;
          if (done) begin
            pc   <= pc_step;
            tcnt <= '0;
            if (instr_count != 16'hFFFF) instr_count <= instr_count + 16'd1;
            state <= start ? FETCH : IDLE;
          end else if (tcnt == TCNT_LAST) begin
            timeout_err <= 1'b1;
            halted      <= 1'b1;
            state       <= HALT;
          end else begin
            tcnt <= tcnt + TCNT_W'(1);
          end
        end

        HALT: begin
          state <= HALT;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer: behavioural 1-cycle ROM, hand-driven done,
// expected values written out per step.
module tb_prog_sequencer;

  logic        Clock;
  logic        Resetn;
  logic        start;
  logic        done;
  logic [15:0] mem_q;
  logic [4:0]  mem_addr;
  logic [15:0] din;
  logic        run;
  logic [4:0]  pc;
  logic        halted;
  logic        timeout_err;
  logic [15:0] instr_count;

  logic [15:0] rom [32];
  int passed;
  int total;

  prog_sequencer #(
    .ADDR_W   (5),
    .END_ADDR (3),
    .TIMEOUT  (8)
  ) dut (
    .Clock       (Clock),
    .Resetn      (Resetn),
    .start       (start),
    .done        (done),
    .mem_q       (mem_q),
    .mem_addr    (mem_addr),
    .din         (din),
    .run         (run),
    .pc          (pc),
    .halted      (halted),
    .timeout_err (timeout_err),
    .instr_count (instr_count)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(posedge Clock) mem_q <= rom[mem_addr];

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    else
      passed++;
  endtask

  task automatic do_reset();
    Resetn = 1'b0;
    start  = 1'b0;
    done   = 1'b0;
    tick();
    tick();
    Resetn = 1'b1;
  endtask

  task automatic wait_run();
    int n;
    n = 0;
    while (!run && n < 10) begin
      tick();
      n++;
    end
    check("run_seen", run, 1);
  endtask

  // Wait for issue, check opcode, answer done on EXEC cycle 'lat', check EXEC din.
  task automatic exec_one(input int lat, input logic [15:0] exp_issue, input logic [15:0] exp_exec);
    wait_run();
    check("issue_din", din, exp_issue);
    $display("issue pc=%0d din=%h lat=%0d count=%0d", pc, din, lat, instr_count);
    tick();
    check("run_one_cycle", run, 0);
    for (int k = 1; k < lat; k++) tick();
    done = 1'b1;
    check("exec_din", din, exp_exec);
    tick();
    done = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic run_seen;
    passed = 0;
    total  = 0;
    Resetn = 1'b0;
    start  = 1'b0;
    done   = 1'b0;
    for (int i = 0; i < 32; i++) rom[i] = 16'h0100 + 16'(i);
    rom[0]  = 16'h000A;
    rom[1]  = 16'h000A;
    rom[2]  = 16'h0058;
    rom[3]  = 16'h1234;
    rom[31] = 16'h0058;

    repeat (2) @(posedge Clock);
    #1;
    check("rst_pc", pc, 0);
    check("rst_din", din, 0);
    check("rst_run", run, 0);
    check("rst_halted", halted, 0);
    check("rst_timeout", timeout_err, 0);
    check("rst_count", instr_count, 0);
    check("rst_addr", mem_addr, 0);
    Resetn = 1'b1;
    tick();
    check("idle_no_run", run, 0);

    // First instruction, cycle by cycle
    start = 1'b1;
    tick();
    check("fetch_run", run, 0);
    check("fetch_addr", mem_addr, 0);
    tick();
    check("issue_run", run, 1);
    check("issue_din0", din, 16'h000A);
    check("issue_addr", mem_addr, 1);
    tick();
    check("exec_run", run, 0);
    done = 1'b1;
    check("exec_din0", din, 16'h000A);
    tick();
    done = 1'b0;
    check("pc_after_1", pc, 1);
    check("count_after_1", instr_count, 1);
    check("gap_run_low", run, 0);
    tick();
    check("gap_run_high", run, 1);
    $display("issue pc=0 din=000a lat=1 count=0");

    exec_one(1, 16'h000A, 16'h000A);
    // mvi whose immediate sits on the sentinel address
    exec_one(2, 16'h0058, 16'h1234);
    check("mvi_pc", pc, 4);
    check("mvi_not_halted", halted, 0);
    check("mvi_count", instr_count, 3);

    // Walk to the last address and wrap through an mvi at 31
    rom[0] = 16'hBEEF;
    for (int i = 4; i <= 30; i++) exec_one(1 + (i % 3), 16'h0100 + 16'(i), 16'h0100 + 16'(i));
    exec_one(1, 16'h0058, 16'hBEEF);
    check("wrap_pc", pc, 1);
    check("wrap_count", instr_count, 31);

    // Pause during EXEC takes effect only after done
    wait_run();
    check("pause_issue_din", din, 16'h000A);
    tick();
    start = 1'b0;
    tick();
    check("pause_exec_din", din, 16'h000A);
    done = 1'b1;
    tick();
    done = 1'b0;
    check("pause_pc", pc, 2);
    check("pause_count", instr_count, 32);
    run_seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      done = (k == 1);
      tick();
      run_seen = run_seen | run;
    end
    done = 1'b0;
    check("idle_no_issue", run_seen, 0);
    check("idle_done_ignored", instr_count, 32);
    start = 1'b1;
    exec_one(1, 16'h0058, 16'h1234);
    check("resume_pc", pc, 4);

    // Sentinel halt after three instructions
    rom[0] = 16'h0011;
    rom[1] = 16'h0022;
    rom[2] = 16'h0203;
    do_reset();
    start = 1'b1;
    exec_one(1, 16'h0011, 16'h0011);
    exec_one(2, 16'h0022, 16'h0022);
    exec_one(3, 16'h0203, 16'h0203);
    tick();
    check("sent_halted", halted, 1);
    check("sent_count", instr_count, 3);
    check("sent_pc", pc, 3);
    check("sent_no_timeout", timeout_err, 0);
    run_seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      done = k[0];
      tick();
      run_seen = run_seen | run;
    end
    done = 1'b0;
    check("sent_no_4th_run", run_seen, 0);
    check("sent_count_frozen", instr_count, 3);

    // Asynchronous reset in the middle of EXEC
    do_reset();
    start = 1'b1;
    exec_one(1, 16'h0011, 16'h0011);
    wait_run();
    tick();
    #2;
    Resetn = 1'b0;
    #1;
    check("arst_pc", pc, 0);
    check("arst_din", din, 0);
    check("arst_run", run, 0);
    check("arst_count", instr_count, 0);
    check("arst_addr", mem_addr, 0);
    @(posedge Clock);
    #1;
    Resetn = 1'b1;
    exec_one(1, 16'h0011, 16'h0011);
    check("arst_restart_pc", pc, 1);
    check("arst_restart_count", instr_count, 1);

    // Timeout: done never arrives
    rom[0] = 16'h000A;
    do_reset();
    start = 1'b1;
    wait_run();
    for (int k = 0; k < 8; k++) tick();
    check("to_not_yet", timeout_err, 0);
    check("to_not_halted_yet", halted, 0);
    tick();
    check("to_err", timeout_err, 1);
    check("to_halted", halted, 1);
    check("to_run", run, 0);
    done = 1'b1;
    tick();
    tick();
    done = 1'b0;
    tick();
    check("to_count", instr_count, 0);
    check("to_pc", pc, 0);
    check("to_still_halted", halted, 1);

    // done during ISSUE is a protocol error
    do_reset();
    start = 1'b1;
    wait_run();
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    check("proto_err", timeout_err, 1);
    check("proto_halted", halted, 1);
    check("proto_count", instr_count, 0);
    check("proto_run", run, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
